// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit
// Description : Load/store front-end for a word-wide data memory. Sub-word
//               stores use read-modify-write; loads are extracted/extended.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
    parameter int ADDR_W     = 9,
    parameter bit BIG_ENDIAN = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              stall,
    output logic [31:0]       load_data,
    output logic              load_valid,
    output logic              misaligned,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_we,
    output logic              mem_read,
    input  logic [31:0]       mem_rdata
);

    localparam logic [1:0] c_IDLE      = 2'd0;
    localparam logic [1:0] c_RMW_READ  = 2'd1;
    localparam logic [1:0] c_RMW_WRITE = 2'd2;

    localparam logic [1:0] c_SZ_BYTE = 2'b00;
    localparam logic [1:0] c_SZ_HALF = 2'b01;
    localparam logic [1:0] c_SZ_WORD = 2'b10;

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [1:0]        r_off;
    logic [1:0]        r_size;
    logic [15:0]       r_data;
    logic [31:0]       r_merge;

    logic [ADDR_W-1:0] w_word_addr;
    logic              w_misaligned;
    logic [4:0]        w_req_shift;
    logic [4:0]        w_rmw_shift;
    logic [31:0]       w_lane;
    logic [31:0]       w_ext;
    logic [31:0]       w_rmw_mask;
    logic [31:0]       w_rmw_data;
    logic [31:0]       w_merged;
    logic              w_unused;

    // Bit position of the addressed lane inside the memory word.
    function automatic logic [4:0] f_lane_shift(input logic [1:0] size, input logic [1:0] off);
        logic [4:0] sh;
        sh = 5'd0;
        if (size == c_SZ_BYTE) begin
            sh = BIG_ENDIAN ? {~off, 3'b000} : {off, 3'b000};
        end else if (size == c_SZ_HALF) begin
            sh = BIG_ENDIAN ? {~off[1], 4'b0000} : {off[1], 4'b0000};
        end
        return sh;
    endfunction

    assign w_word_addr  = req_addr[ADDR_W+1:2];
    assign w_unused     = ^req_addr[31:ADDR_W+2];
    assign w_misaligned = (req_size == 2'b11)
                        | ((req_size == c_SZ_HALF) & req_addr[0])
                        | ((req_size == c_SZ_WORD) & (req_addr[1:0] != 2'b00));

    assign w_req_shift = f_lane_shift(req_size, req_addr[1:0]);
    assign w_lane      = mem_rdata >> w_req_shift;

    always_comb begin
        w_ext = mem_rdata;
        case (req_size)
            c_SZ_BYTE: w_ext = req_unsigned ? {24'h0, w_lane[7:0]}
                                            : {{24{w_lane[7]}}, w_lane[7:0]};
            c_SZ_HALF: w_ext = req_unsigned ? {16'h0, w_lane[15:0]}
                                            : {{16{w_lane[15]}}, w_lane[15:0]};
            default:   w_ext = mem_rdata;
        endcase
    end

    assign w_rmw_shift = f_lane_shift(r_size, r_off);
    assign w_rmw_mask  = ((r_size == c_SZ_BYTE) ? 32'h0000_00FF : 32'h0000_FFFF) << w_rmw_shift;
    assign w_rmw_data  = {16'h0, r_data} << w_rmw_shift;
    assign w_merged    = (mem_rdata & ~w_rmw_mask) | (w_rmw_data & w_rmw_mask);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_addr  <= '0;
            r_off   <= 2'b00;
            r_size  <= 2'b00;
            r_data  <= 16'h0;
            r_merge <= 32'h0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (req_valid && req_write && !w_misaligned && (req_size != c_SZ_WORD)) begin
                        r_addr  <= w_word_addr;
                        r_off   <= req_addr[1:0];
                        r_size  <= req_size;
                        r_data  <= req_wdata[15:0];
                        r_state <= c_RMW_READ;
                    end
                end
                c_RMW_READ: begin
                    r_merge <= w_merged;
                    r_state <= c_RMW_WRITE;
                end
                c_RMW_WRITE: r_state <= c_IDLE;
                default:     r_state <= c_IDLE;
            endcase
        end
    end

    // Outputs are held quiet for the whole time reset is asserted.
    always_comb begin
        stall      = 1'b0;
        load_data  = 32'h0;
        load_valid = 1'b0;
        misaligned = 1'b0;
        mem_addr   = '0;
        mem_wdata  = 32'h0;
        mem_we     = 1'b0;
        mem_read   = 1'b0;
        if (!rst) begin
            case (r_state)
                c_IDLE: begin
                    if (req_valid) begin
                        if (w_misaligned) begin
                            misaligned = 1'b1;
                        end else if (!req_write) begin
                            mem_read   = 1'b1;
                            mem_addr   = w_word_addr;
                            load_valid = 1'b1;
                            load_data  = w_ext;
                        end else if (req_size == c_SZ_WORD) begin
                            mem_we    = 1'b1;
                            mem_addr  = w_word_addr;
                            mem_wdata = req_wdata;
                        end else begin
                            stall = 1'b1;
                        end
                    end
                end
                c_RMW_READ: begin
                    stall    = 1'b1;
                    mem_read = 1'b1;
                    mem_addr = r_addr;
                end
                c_RMW_WRITE: begin
                    mem_we    = 1'b1;
                    mem_addr  = r_addr;
                    mem_wdata = r_merge;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store front-end that sits directly upstream of the word-wide data memory in the MIPS datapath.
- Accepts byte, halfword and word requests from the MEM stage and maps each byte address to a word address.
- Performs sub-word stores as a read-modify-write sequence, because the memory only writes whole words.
- Extracts and sign- or zero-extends load results, and stalls the pipeline while a read-modify-write is in progress.

Parameters:
ADDR_W, 9, word-address width driven to memory; byte address bits [ADDR_W+1:2] are used and upper bits are ignored (wrap).
BIG_ENDIAN, 0, 0 = byte offset 0 is bits [7:0]; 1 = byte offset 0 is bits [31:24].

Ports:
clk  in  1  system clock; all state updates on posedge.
rst  in  1  asynchronous, active-high reset.
req_valid  in  1  request present this cycle.
req_write  in  1  1 = store, 0 = load.
req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
req_unsigned  in  1  load zero-extends when 1 (lbu/lhu).
req_addr  in  32  byte address.
req_wdata  in  32  store data; the sub-word value is in the low bits.
stall  out  1  pipeline must hold the MEM stage.
load_data  out  32  extended load result.
load_valid  out  1  load_data is valid this cycle.
misaligned  out  1  one-cycle error flag; the request is dropped.
mem_addr  out  ADDR_W  word address to memory.
mem_wdata  out  32  word to write.
mem_we  out  1  memory write enable.
mem_read  out  1  memory read enable (memory captures the address while high).
mem_rdata  in  32  memory read word (combinational from memory).

Behaviour:
Reset and outputs
- Reset is asynchronous and active-high: rst forces state to IDLE and clears the latched address, data, size and merge registers.
- While rst is high or IDLE has no request: stall=0, load_valid=0, misaligned=0, mem_we=0, mem_read=0, mem_addr=0, mem_wdata=0, load_data=0.

State machine (IDLE, RMW_READ, RMW_WRITE)
- Outputs are combinational from state and inputs.
- Alignment check happens in IDLE: half with addr[0]=1, word with addr[1:0]!=0, or size=11. Result: misaligned=1 for that cycle, no memory access, load_valid=0, stall=0, state stays IDLE.
- IDLE, aligned load: mem_read=1 and mem_addr=req_addr[ADDR_W+1:2] in the same cycle. load_data is extracted from mem_rdata and load_valid=1 in that cycle. Zero latency, no stall.
- Load lane select: byte lane = addr[1:0]; half lane = addr[1]. Mapping is per BIG_ENDIAN. Sign-extend unless req_unsigned=1. A word load ignores req_unsigned.
- IDLE, aligned word store: mem_we=1, mem_wdata=req_wdata, mem_addr driven in the same cycle. No stall; state stays IDLE.
- IDLE, aligned byte/half store:
  - Latch word address, byte offset, size and data.
  - Assert stall=1.
  - Go to RMW_READ.
  - No memory access this cycle.
- RMW_READ:
  - Outputs: mem_read=1, mem_addr=latched address, stall=1.
  - At posedge: merge_reg <= mem_rdata with the target lane(s) replaced by latched data[7:0] or [15:0].
  - Go to RMW_WRITE.
- RMW_WRITE:
  - Outputs: mem_we=1, mem_wdata=merge_reg, mem_addr=latched address, stall=0.
  - Go to IDLE.
- Sub-word store total: 3 cycles, with stall high for the first 2.

Boundary conditions
- req_* inputs are ignored in RMW_READ and RMW_WRITE. The pipeline holds them under stall.
- A request seen in the cycle after RMW_WRITE is handled as new.
- Reset mid-RMW returns to IDLE immediately: no write occurs and memory is unchanged.
- Address wrap: req_addr bits above ADDR_W+1 are ignored, so 0x800 aliases word 0.
- req_valid=0 produces no memory activity, regardless of the other req_* inputs.

Test Plan:
1. Memory word 5 = 0x8899AABB; load byte signed, addr 0x15 (lane 1, BIG_ENDIAN=0) -> same cycle load_valid=1, load_data=0xFFFFFFAA. Repeat with unsigned -> 0x000000AA.
2. Word 5 = 0x8899AABB; store byte 0x11 to addr 0x16 -> stall high 2 cycles, mem_read in cycle 2, mem_we in cycle 3 with mem_wdata=0x8811AABB; subsequent word load of 0x14 returns 0x8811AABB.
3. Store half 0xCAFE to addr 0x22 (BIG_ENDIAN=1), word 8 = 0x12345678 -> written word 0x1234CAFE; store word 0xDEADBEEF to 0x24 -> mem_we same cycle, stall never high.
4. Load half at addr 0x13, store word at 0x26, size=11 at 0x20 -> each: misaligned=1 one cycle, mem_we=0, mem_read=0, stall=0, memory unchanged.
5. Start byte store to 0x30; assert rst during RMW_READ -> stall and mem_we drop immediately, state IDLE, word 12 unchanged; next load works normally.
6. During RMW_READ, change req_* to a word store at 0x40 -> ignored; only the original merged write occurs, word 16 unchanged.
